// File: rtl/shifter_pkg.sv
// Shared types and constants for the iterative right shifter.
package shifter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } shift_state_t;

  localparam int unsigned SHIFT_STEP = 2;
  localparam int unsigned WORD_W     = 32;

endpackage

// File: rtl/right_shift_step.sv
// Combinational right shift by one or two bits with a caller-supplied fill bit;
// the direction-reversed analogue of the two-bit left shifter.
module right_shift_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             fill,
  input  logic             two,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    if (two) result = {fill, fill, value[WIDTH-1:2]};
    else     result = {fill, value[WIDTH-1:1]};
  end

endmodule

// File: rtl/seq_right_shifter.sv
// Multi-cycle logical/arithmetic right shifter: two bits per clock, Done pulse on completion.
module seq_right_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH   = WORD_W,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [WIDTH-1:0]   ValueIn,
  input  logic [SHAMT_W-1:0] ShiftAmt,
  input  logic               Arithmetic,
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   ValueOut
);

  shift_state_t       state, next_state;
  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] remaining;
  logic               mode;
  logic [WIDTH-1:0]   value_out;

  logic               step_two;
  logic               fill;
  logic               last_step;
  logic [SHAMT_W-1:0] step_dec;
  logic [WIDTH-1:0]   stepped;

  // Sign is re-read from the accumulator each step so repeated steps keep extending it.
  always_comb begin
    step_two  = (remaining >= SHAMT_W'(SHIFT_STEP));
    fill      = mode & acc[WIDTH-1];
    last_step = (remaining <= SHAMT_W'(SHIFT_STEP));
    step_dec  = step_two ? SHAMT_W'(SHIFT_STEP) : SHAMT_W'(1);
  end

  right_shift_step #(.WIDTH(WIDTH)) u_step (
    .value  (acc),
    .fill   (fill),
    .two    (step_two),
    .result (stepped)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (Start) next_state = (ShiftAmt != '0) ? SHIFT : DONE;
      SHIFT:   if (last_step) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ValueOut is loaded on the edge entering DONE so it is already valid while Done is high.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc       <= '0;
      remaining <= '0;
      mode      <= 1'b0;
      value_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            acc       <= ValueIn;
            remaining <= ShiftAmt;
            mode      <= Arithmetic;
            if (ShiftAmt == '0) value_out <= ValueIn;
          end
        end
        SHIFT: begin
          acc       <= stepped;
          remaining <= remaining - step_dec;
          if (last_step) value_out <= stepped;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    Busy     = (state != IDLE);
    Done     = (state == DONE);
    ValueOut = value_out;
  end

endmodule

// File: tb/tb_seq_right_shifter.sv
// Directed bench for seq_right_shifter: vector table plus multi-cycle corner sequences.
module tb_seq_right_shifter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [31:0] ValueIn;
  logic [4:0]  ShiftAmt;
  logic        Arithmetic;
  logic        Busy;
  logic        Done;
  logic [31:0] ValueOut;

  int unsigned checks = 0;
  int unsigned fails  = 0;
  logic [31:0] last_out;

  seq_right_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .ValueIn    (ValueIn),
    .ShiftAmt   (ShiftAmt),
    .Arithmetic (Arithmetic),
    .Busy       (Busy),
    .Done       (Done),
    .ValueOut   (ValueOut)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] value;
    logic [4:0]  amt;
    logic        arith;
    logic [31:0] expected;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Issue one op and check Busy/Done/ValueOut in every cycle from k+1 to k+N+2.
  task automatic run_op(input logic [31:0] v, input logic [4:0] amt, input logic a,
                        input logic [31:0] want, input string tag);
    int unsigned n;
    n = (int'(amt) + 1) / 2;
    @(negedge Clk);
    Start = 1'b1; ValueIn = v; ShiftAmt = amt; Arithmetic = a;
    @(posedge Clk); #1;
    Start = 1'b0; ValueIn = '0; ShiftAmt = '0; Arithmetic = 1'b0;
    for (int unsigned c = 1; c <= n + 2; c++) begin
      check({tag, " busy"}, 32'(Busy), 32'(c <= n + 1));
      check({tag, " done"}, 32'(Done), 32'(c == n + 1));
      check({tag, " value"}, ValueOut, (c >= n + 1) ? want : last_out);
      if (c < n + 2) begin
        @(posedge Clk); #1;
      end
    end
    last_out = want;
  endtask

  vec_t vecs[10];
  int unsigned done_cnt;

  initial begin
    vecs[0] = '{32'h8000_0000, 5'd4,  1'b0, 32'h0800_0000};
    vecs[1] = '{32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF};
    vecs[2] = '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001};
    vecs[3] = '{32'hF000_0000, 5'd5,  1'b1, 32'hFF80_0000};
    vecs[4] = '{32'hF000_0000, 5'd5,  1'b0, 32'h0780_0000};
    vecs[5] = '{32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF};
    vecs[6] = '{32'h1234_5678, 5'd1,  1'b0, 32'h091A_2B3C};
    vecs[7] = '{32'h8000_0000, 5'd1,  1'b1, 32'hC000_0000};
    vecs[8] = '{32'h7FFF_FFFF, 5'd30, 1'b1, 32'h0000_0001};
    vecs[9] = '{32'h8000_0001, 5'd2,  1'b0, 32'h2000_0000};

    Reset = 1'b1; Start = 1'b0; ValueIn = '0; ShiftAmt = '0; Arithmetic = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("reset busy", 32'(Busy), 32'd0);
    check("reset done", 32'(Done), 32'd0);
    check("reset value", ValueOut, 32'd0);
    last_out = '0;
    @(negedge Clk); Reset = 1'b0;

    for (int unsigned i = 0; i < 10; i++)
      run_op(vecs[i].value, vecs[i].amt, vecs[i].arith, vecs[i].expected, $sformatf("vec%0d", i));

    // Start during SHIFT must be ignored; exactly one Done at k+5.
    @(negedge Clk);
    Start = 1'b1; ValueIn = 32'h1234_5678; ShiftAmt = 5'd8; Arithmetic = 1'b0;
    @(posedge Clk); #1;
    Start = 1'b0;
    done_cnt = 0;
    for (int unsigned c = 1; c <= 8; c++) begin
      if (Done) done_cnt++;
      check("ign done", 32'(Done), 32'(c == 5));
      if (c == 5) check("ign value", ValueOut, 32'h0012_3456);
      @(negedge Clk);
      if (c == 2) begin
        Start = 1'b1; ValueIn = 32'hFFFF_FFFF; ShiftAmt = 5'd2; Arithmetic = 1'b1;
      end else begin
        Start = 1'b0;
      end
      @(posedge Clk); #1;
    end
    check("ign done count", done_cnt, 32'd1);
    check("ign hold", ValueOut, 32'h0012_3456);
    check("ign idle", 32'(Busy), 32'd0);
    last_out = 32'h0012_3456;

    // Start held through DONE is accepted in the following IDLE cycle.
    @(negedge Clk);
    Start = 1'b1; ValueIn = 32'hCAFE_0001; ShiftAmt = 5'd0; Arithmetic = 1'b0;
    @(posedge Clk); #1;
    check("hold c1 done", 32'(Done), 32'd1);
    @(posedge Clk); #1;
    check("hold c2 busy", 32'(Busy), 32'd0);
    @(posedge Clk); #1;
    check("hold c3 done", 32'(Done), 32'd1);
    check("hold c3 value", ValueOut, 32'hCAFE_0001);
    @(negedge Clk); Start = 1'b0;
    @(posedge Clk); #1;
    last_out = 32'hCAFE_0001;

    // Reset at k+3 of an amt-20 op aborts it with no Done.
    @(negedge Clk);
    Start = 1'b1; ValueIn = 32'hAAAA_5555; ShiftAmt = 5'd20; Arithmetic = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    check("abort busy", 32'(Busy), 32'd1);
    @(posedge Clk); #1;
    @(negedge Clk); Reset = 1'b1;
    @(posedge Clk); #1;
    check("abort rst busy", 32'(Busy), 32'd0);
    check("abort rst done", 32'(Done), 32'd0);
    check("abort rst value", ValueOut, 32'd0);
    @(negedge Clk); Reset = 1'b0;
    done_cnt = 0;
    for (int unsigned c = 0; c < 15; c++) begin
      @(posedge Clk); #1;
      if (Done) done_cnt++;
    end
    check("abort no done", done_cnt, 32'd0);
    check("abort value held", ValueOut, 32'd0);
    last_out = '0;
    run_op(32'h0000_F000, 5'd12, 1'b0, 32'h0000_000F, "post");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/seq_right_shifter.md
# seq_right_shifter

Iterative right shifter for the datapath, the counterpart to the two-bit left shifter used in jump-address formation. It accepts a 32-bit operand and a 5-bit shift amount on a Start pulse, shifts the value right by up to two bits per clock, logical or arithmetic, and reports the result with a one-cycle Done pulse. It serves the multi-cycle SRL/SRA/SRLV/SRAV path, where a full barrel shifter is not justified.

## Interface
- WIDTH, 32: operand and result width.
- SHAMT_W, $clog2(WIDTH) = 5: shift-amount width.
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request pulse; sampled only in IDLE.
- ValueIn  input  WIDTH  operand, captured with Start.
- ShiftAmt  input  SHAMT_W  shift distance, 0..WIDTH-1, captured with Start.
- Arithmetic  input  1  1 = sign fill (SRA), 0 = zero fill (SRL), captured with Start.
- Busy  output  1  high whenever state is not IDLE.
- Done  output  1  one-cycle pulse; ValueOut is valid in that cycle.
- ValueOut  output  WIDTH  result register; holds the last result until the next accepted Start completes.

## Operation
- Internal registers:
  - Acc (WIDTH)
  - Remaining (SHAMT_W)
  - Mode (1)
  - state ∈ {IDLE, SHIFT, DONE}
- Fill bit is Mode ? Acc[WIDTH-1] : 0. In arithmetic mode the sign is re-read from Acc on every step.
- IDLE:
  - Start=1 captures ValueIn→Acc, ShiftAmt→Remaining, Arithmetic→Mode.
  - Next state is SHIFT if ShiftAmt≠0, otherwise DONE.
  - Start=0: stay in IDLE; all registers hold.
- SHIFT, each cycle:
  - If Remaining≥2: Acc shifted right 2 with fill, Remaining−=2.
  - If Remaining==1: Acc shifted right 1 with fill, Remaining=0.
  - Move to DONE on the cycle whose update drives Remaining to 0.
- DONE: Done=1 and ValueOut=Acc (registered). Next state is IDLE unconditionally.
- Start is ignored in SHIFT and DONE; it is never queued. A Start held high through DONE is accepted in the following IDLE cycle.
- Reset (any state, including mid-SHIFT):
  - state=IDLE; Acc, Remaining, Mode, ValueOut = 0; Busy=0, Done=0.
  - An aborted operation never produces Done.
- ShiftAmt cannot exceed WIDTH-1 by width, so no overflow case exists.

## Timing
- Start sampled high at edge k, with state IDLE.
- Let N = ceil(ShiftAmt/2), range 0..16.
- SHIFT occupies cycles k+1 .. k+N.
- Done=1 and ValueOut valid in cycle k+N+1; ShiftAmt=0 gives Done at k+1.
- Busy=1 in cycles k+1 .. k+N+1. IDLE is back at k+N+2, the earliest next Start.
- Worst case (ShiftAmt=31): Done at k+17; back-to-back throughput is one op per 18 cycles.
- ValueOut changes only at the edge entering DONE and on reset. It is stable in all other cycles.
- No combinational path from inputs to outputs.

## Structure
- Package shifter_pkg holds:
  - typedef enum logic [1:0] shift_state_t {IDLE, SHIFT, DONE}
  - localparam SHIFT_STEP = 2
  - localparam WORD_W = 32
- One combinational sub-module, right_shift_step:
  - Inputs: value (WIDTH), fill (1), two (1).
  - Output: value shifted right by 1 or 2 with fill.
  - It is the direction-reversed analogue of the two-bit left shifter.
- The top module holds the FSM, Acc/Remaining/Mode registers and the ValueOut register.

## Test plan
- Logical, ValueIn=0x8000_0000, ShiftAmt=4 -> Done only at k+3, ValueOut=0x0800_0000, Busy high k+1..k+3.
- ValueIn=0x8000_0000, ShiftAmt=31:
  - Arithmetic -> Done at k+17, ValueOut=0xFFFF_FFFF.
  - Logical -> Done at k+17, ValueOut=0x0000_0001.
- Odd distance, ValueIn=0xF000_0000, ShiftAmt=5:
  - Arithmetic -> Done at k+4, 0xFF80_0000.
  - Logical -> Done at k+4, 0x0780_0000.
- ShiftAmt=0, ValueIn=0xDEAD_BEEF -> Done at k+1, ValueOut=0xDEAD_BEEF, no SHIFT cycle.
- Start with 0x1234_5678/amt 8, then Start at k+2 with 0xFFFF_FFFF/amt 2:
  - Second request ignored.
  - Done at k+5, ValueOut=0x0012_3456.
  - Only one Done pulse.
- Reset at k+3 of an amt-20 op -> from next edge, Busy=0, Done=0, ValueOut=0. No Done is ever emitted for that op. A fresh Start then completes normally.
